// File: rtl/result_fifo_bank.sv
// Multi-channel result buffer: one FIFO per channel, written by the compute engines and
// drained by the host over an Avalon-MM read port, with push totals, occupancy and overflow status.
module result_fifo_bank #(
   parameter int NCH   = 3,
   parameter int DW    = 8,
   parameter int DEPTH = 1024,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    wr_en,
   input  logic [NCH*DW-1:0] wr_data,
   input  logic              chipselect,
   input  logic              read,
   input  logic [4:0]        address,
   output logic [31:0]       readdata,
   output logic [NCH-1:0]    empty,
   output logic [NCH-1:0]    full,
   output logic [NCH*DW-1:0] dbg_last
);

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [NCH-1:0][AW-1:0] wr_ptr;
   logic [NCH-1:0][AW-1:0] rd_ptr;
   logic [NCH-1:0][AW:0]   level;
   logic [NCH-1:0][31:0]   push_total;
   logic [NCH-1:0]         ovf;
   logic [NCH-1:0][DW-1:0] head;

   logic [NCH-1:0] pop;
   logic [NCH-1:0] push_ok;
   logic [NCH-1:0] overflow;
   logic [NCH-1:0] ovf_clr;
   logic [31:0]    rd_value;

   logic       access;
   logic [1:0] func;
   logic [2:0] ch;

   assign access = chipselect && read;
   assign func   = address[4:3];
   assign ch     = address[2:0];

   // Channel numbers at or above NCH match no channel, so they read 0 with no side effects.
   always_comb begin
      rd_value = '0;
      for (int c = 0; c < NCH; c++) begin
         empty[c]    = (level[c] == '0);
         full[c]     = (level[c] == LVL_FULL);
         pop[c]      = access && (func == 2'd0) && (ch == 3'(c)) && (level[c] != '0);
         ovf_clr[c]  = access && (func == 2'd3) && (ch == 3'(c));
         push_ok[c]  = wr_en[c] && ((level[c] != LVL_FULL) || pop[c]);
         overflow[c] = wr_en[c] && !push_ok[c];
         if (ch == 3'(c)) begin
            case (func)
               2'd0:    rd_value = (level[c] != '0) ? 32'(head[c]) : 32'hFFFF_FFFF;
               2'd1:    rd_value = push_total[c];
               2'd2:    rd_value = 32'(level[c]);
               default: rd_value = {29'b0, ovf[c], full[c], empty[c]};
            endcase
         end
      end
   end

   // Storage is not reset; only the pointers decide which entries are live.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [DW-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (!reset && push_ok[g]) begin
            mem[wr_ptr[g]] <= wr_data[g*DW +: DW];
         end
      end

      assign head[g] = mem[rd_ptr[g]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         push_total <= '0;
         ovf        <= '0;
         dbg_last   <= '0;
         readdata   <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (push_ok[c]) begin
               wr_ptr[c]               <= wr_ptr[c] + AW'(1);
               push_total[c]           <= push_total[c] + 32'd1;
               dbg_last[c*DW +: DW]    <= wr_data[c*DW +: DW];
            end
            if (pop[c]) begin
               rd_ptr[c] <= rd_ptr[c] + AW'(1);
            end
            if (push_ok[c] && !pop[c]) begin
               level[c] <= level[c] + (AW+1)'(1);
            end else if (pop[c] && !push_ok[c]) begin
               level[c] <= level[c] - (AW+1)'(1);
            end
            // A same-cycle overflow beats the read-to-clear.
            if (overflow[c]) begin
               ovf[c] <= 1'b1;
            end else if (ovf_clr[c]) begin
               ovf[c] <= 1'b0;
            end
         end
         if (access) begin
            readdata <= rd_value;
         end
      end
   end

endmodule

// File: tb/tb_result_fifo_bank.sv
// Self-checking bench for result_fifo_bank: table-driven basics plus hand-written
// overflow, full-with-pop, pointer-wrap and mid-stream reset sequences.
module tb_result_fifo_bank;

   localparam int NCH = 3;
   localparam int DW  = 8;
   localparam int DP  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    wr_en;
   logic [NCH*DW-1:0] wr_data;
   logic              chipselect;
   logic              read;
   logic [4:0]        address;
   logic [31:0]       readdata;
   logic [NCH-1:0]    empty;
   logic [NCH-1:0]    full;
   logic [NCH*DW-1:0] dbg_last;

   int nCompared = 0;
   int nFailed   = 0;
   logic [31:0] expq[$];

   typedef struct {
      logic [2:0]  we;
      logic [23:0] wd;
      bit          rd;
      logic [1:0]  func;
      logic [2:0]  ch;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   result_fifo_bank #(.NCH(NCH), .DW(DW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .chipselect(chipselect), .read(read), .address(address),
      .readdata(readdata), .empty(empty), .full(full), .dbg_last(dbg_last)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected read result, compare it once it is registered.
   task automatic applyStimulus(input logic [2:0] we, input logic [23:0] wd, input bit rd,
                                input logic [1:0] func, input logic [2:0] ch,
                                input logic [31:0] exp, input string name);
      wr_en      = we;
      wr_data    = wd;
      chipselect = rd;
      read       = rd;
      address    = {func, ch};
      if (rd) expq.push_back(exp);
      @(posedge clk);
      #1;
      if (rd) checkOutput(name, readdata, expq.pop_front());
      wr_en      = '0;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; wr_en = '0; wr_data = '0; chipselect = 1'b0; read = 1'b0; address = '0;

      vecs[0]  = '{3'b000, 24'h0,      1'b1, 2'd3, 3'd0, 32'd1};
      vecs[1]  = '{3'b000, 24'h0,      1'b1, 2'd2, 3'd0, 32'd0};
      vecs[2]  = '{3'b000, 24'h0,      1'b1, 2'd0, 3'd0, 32'hFFFF_FFFF};
      vecs[3]  = '{3'b010, 24'h000500, 1'b0, 2'd0, 3'd0, 32'd0};
      vecs[4]  = '{3'b010, 24'h000600, 1'b0, 2'd0, 3'd0, 32'd0};
      vecs[5]  = '{3'b010, 24'h000700, 1'b0, 2'd0, 3'd0, 32'd0};
      vecs[6]  = '{3'b000, 24'h0,      1'b1, 2'd0, 3'd1, 32'd5};
      vecs[7]  = '{3'b000, 24'h0,      1'b1, 2'd0, 3'd1, 32'd6};
      vecs[8]  = '{3'b000, 24'h0,      1'b1, 2'd0, 3'd1, 32'd7};
      vecs[9]  = '{3'b000, 24'h0,      1'b1, 2'd0, 3'd1, 32'hFFFF_FFFF};
      vecs[10] = '{3'b000, 24'h0,      1'b1, 2'd1, 3'd1, 32'd3};
      vecs[11] = '{3'b000, 24'h0,      1'b1, 2'd2, 3'd1, 32'd0};

      doReset();
      checkOutput("reset_readdata", readdata, 32'd0);
      checkOutput("reset_empty", 32'(empty), 32'h7);
      checkOutput("reset_full", 32'(full), 32'h0);

      for (int i = 0; i < 12; i++)
         applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].rd, vecs[i].func, vecs[i].ch,
                       vecs[i].exp, $sformatf("vec%0d", i));

      // Overflow on ch2: DP accepted, two dropped.
      for (int i = 0; i < DP + 2; i++)
         applyStimulus(3'b100, 24'(i) << 16, 1'b0, 2'd0, 3'd0, 32'd0, "fill2");
      checkOutput("full_ch2", 32'(full), 32'h4);
      checkOutput("dbg_last_ch2", 32'(dbg_last[23:16]), 32'(DP - 1));
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd1, 3'd2, 32'(DP), "total_ch2");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd3, 3'd2, 32'd6, "status_ovf_ch2");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd3, 3'd2, 32'd2, "status_clr_ch2");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd2, 3'd2, 32'(DP), "level_ch2");

      // Full ch0 with simultaneous push and pop.
      for (int i = 0; i < DP; i++)
         applyStimulus(3'b001, 24'(100 + i), 1'b0, 2'd0, 3'd0, 32'd0, "fill0");
      applyStimulus(3'b001, 24'hAA, 1'b1, 2'd0, 3'd0, 32'd100, "full_pushpop");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd2, 3'd0, 32'(DP), "level_full0");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd3, 3'd0, 32'd2, "status_full0");
      for (int i = 1; i < DP; i++)
         applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'd0, 32'(100 + i), "drain0");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'd0, 32'hAA, "last_is_x");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'd0, 32'hFFFF_FFFF, "drained0");

      // Three full passes of ch0 so both pointers wrap several times.
      doReset();
      for (int b = 0; b < 3; b++) begin
         for (int j = 0; j < DP; j++)
            applyStimulus(3'b001, 24'(b*DP + j), 1'b0, 2'd0, 3'd0, 32'd0, "wrap_push");
         for (int j = 0; j < DP; j++)
            applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'd0, 32'(b*DP + j), "wrap_pop");
      end
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd1, 3'd0, 32'(3*DP), "wrap_total");

      // Reset mid-stream with a push and a read presented in the reset cycle.
      applyStimulus(3'b101, 24'h090009, 1'b0, 2'd0, 3'd0, 32'd0, "push9");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd1, 3'd0, 32'(3*DP + 1), "total_pre_reset");
      reset = 1'b1; wr_en = 3'b101; wr_data = 24'h090009;
      chipselect = 1'b1; read = 1'b1; address = 5'd0;
      @(posedge clk);
      #1;
      reset = 1'b0; wr_en = '0; chipselect = 1'b0; read = 1'b0;
      checkOutput("rst_readdata", readdata, 32'd0);
      checkOutput("rst_dbg_last", 32'(dbg_last), 32'd0);
      checkOutput("rst_empty", 32'(empty), 32'h7);
      checkOutput("rst_full", 32'(full), 32'h0);
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd2, 3'd0, 32'd0, "rst_level0");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd2, 3'd2, 32'd0, "rst_level2");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd1, 3'd0, 32'd0, "rst_total0");

      // Out-of-range channel reads 0 and disturbs nothing.
      applyStimulus(3'b001, 24'h000009, 1'b0, 2'd0, 3'd0, 32'd0, "push9_again");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd1, 3'd0, 32'd1, "total_after");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'(NCH), 32'd0, "bad_ch_pop");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd2, 3'd0, 32'd1, "level_kept");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd3, 3'd7, 32'd0, "bad_ch_status");
      applyStimulus(3'b000, 24'h0, 1'b1, 2'd0, 3'd0, 32'd9, "pop9");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule

// File: doc/result_fifo_bank.md
# result_fifo_bank

Parametrised multi-channel result buffer: one independent FIFO per result channel. Compute engines push results through per-channel write strobes. The host drains them over an Avalon-MM slave read port. Per-channel push totals, occupancy and sticky overflow status are readable for software flow control. It sits between the engine outputs and the HPS bridge, replacing the fixed three-channel, counter-only buffer.

## Interface
- NCH, 3: number of channels, 1..8.
- DW, 8: result data width, 1..32.
- DEPTH, 1024: entries per channel FIFO, power of two, ≥2.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).

- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  NCH  per-channel push strobe, bit c = channel c.
- wr_data  in  NCH*DW  push data, channel c at [c*DW +: DW].
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe, valid only with chipselect.
- address  in  5  {func[1:0], ch[2:0]}.
- readdata  out  32  registered read result.
- empty  out  NCH  per-channel empty flag, combinational from state.
- full  out  NCH  per-channel full flag, combinational from state.
- dbg_last  out  NCH*DW  last accepted push value per channel (replaces hex taps).

## Operation
- Per channel: storage DEPTH×DW, rd/wr pointers AW bits that wrap modulo DEPTH, level counter AW+1 bits in 0..DEPTH.
- Push: accepted when wr_en[c] and (level<DEPTH or pop on c in same cycle). Accepted push writes mem[wr_ptr], increments wr_ptr, increments push_total[c] (32-bit, wraps at 2^32), and updates dbg_last[c].
- Push while full with no same-cycle pop: data dropped, pointers and push_total unchanged, ovf[c] set (sticky).
- Host access occurs when chipselect&&read. ch≥NCH gives readdata=0 and no side effects. func decode:
  - 0 (pop): if level>0, readdata={0, mem[rd_ptr]} zero-extended, rd_ptr++, level--. If empty, readdata=32'hFFFF_FFFF and no state change.
  - 1: readdata=push_total[c].
  - 2: readdata=level zero-extended.
  - 3: readdata={29'b0, ovf[c], full[c], empty[c]}. Reading func 3 clears ovf[c] (read-to-clear). An overflow event in the same cycle wins and ovf stays 1.
- Simultaneous push and pop on the same channel: both take effect, level unchanged. On empty, the pop returns FFFF_FFFF and the push is stored (no bypass), so level becomes 1.
- No host access: readdata holds its previous value.
- Reset (any time, including mid-burst): pointers, level, push_total, ovf, dbg_last and readdata all go to 0. empty=all ones, full=0. The wr_en/read inputs in the reset cycle are ignored.

## Timing
- Read latency is 1 cycle: readdata is valid on the edge after chipselect&&read is sampled. No waitrequest is used.
- Back-to-back pops every cycle are supported. Each pop returns a distinct entry with no duplicate or skipped reads.
- Push to visibility: an entry pushed at edge N can be popped by a read sampled at edge N+1 (readdata valid after N+1).
- empty/full/level update on the edge after the push/pop that changes them.
- Pointer wrap at DEPTH−1→0 is seamless.

## Test plan
- Reset then func 3 read on ch0 → readdata=1 (empty). func 2 → 0. func 0 → FFFF_FFFF.
- Push 5,6,7 on ch1, then pop ×3 back-to-back on ch1 → 5,6,7. Next pop → FFFF_FFFF. func 1 → 3.
- Fill ch2 with DEPTH pushes, then 2 more → full[2]=1, func 1=DEPTH, func 3=6 (ovf|full). Second func 3 read → 2 (ovf cleared).
- At full ch0, simultaneous push X and pop → pop returns oldest entry, level stays DEPTH, ovf stays 0, X is read last.
- Push/pop 3×DEPTH entries with an incrementing pattern on ch0 → all returned in order across wrap, push_total=3*DEPTH.
- Push 9 on ch0 and ch2, assert reset one cycle mid-stream → level 0, dbg_last 0, readdata 0. Access with ch=NCH → readdata 0, no state change.
